// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the parametrised SPI slave.
// FSM state encodings are plain constants so older tools can consume them.
package spi_slave_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CMD       = 3'd1;
  localparam state_t ST_WRITE     = 3'd2;
  localparam state_t ST_READ_ADD  = 3'd3;
  localparam state_t ST_READ_DATA = 3'd4;
  localparam state_t ST_WAIT_TX   = 3'd5;
  localparam state_t ST_TX_SHIFT  = 3'd6;
  localparam state_t ST_DONE      = 3'd7;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  // Bit counter only ever holds values 0..max(cw,dw).
  function automatic int cnt_width(input int cw, input int dw);
    return $clog2(((cw > dw) ? cw : dw) + 1);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Generic MSB-first shift register with parallel load (load wins over shift).
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[W-2:0], shift_in};
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave oversampled at clk: CW command bits then DW payload bits, MSB first,
// with a ready/valid read-data handshake, abort detection and optional read-address check.
//
//   state      | meaning
//   IDLE       | waiting for SS_n low, MISO forced 0
//   CMD        | shifting in command bits
//   WRITE      | shifting in write payload
//   READ_ADD   | shifting in read address
//   READ_DATA  | shifting in read-data command payload
//   WAIT_TX    | tx_ready high, waiting for tx_valid
//   TX_SHIFT   | driving DW bits on MISO
//   DONE       | frame over, waiting for SS_n high
module spi_slave_param #(
  parameter int DW         = 8,
  parameter int CW         = 2,
  parameter bit CHECK_ADDR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SS_n,
  input  logic             MOSI,
  output logic             MISO,
  output logic [CW+DW-1:0] rx_data,
  output logic             rx_valid,
  input  logic [DW-1:0]    tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             frame_err,
  output logic             busy
);
  import spi_slave_pkg::*;

  localparam int CNT_W = cnt_width(CW, DW);
  localparam int FW    = CW + DW;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [FW-1:0]    rx_q;
  logic [DW-1:0]    tx_q;
  cmd_t             cmd_dec;
  logic             addr_seen, miso_n, err_n, abort;
  logic             shift_rx, load_tx, shift_tx, last_ok, set_addr, clr_addr;
  logic             cap_pend, val_pend;

  // Command and payload share one shift register, so after the last bit it already holds {cmd, payload}.
  spi_shift_reg #(.W(FW)) u_rx_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .load_data ({FW{1'b0}}),
    .shift_en  (shift_rx),
    .shift_in  (MOSI),
    .q         (rx_q)
  );

  spi_shift_reg #(.W(DW)) u_tx_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_tx),
    .load_data (tx_data),
    .shift_en  (shift_tx),
    .shift_in  (1'b0),
    .q         (tx_q)
  );

  assign cmd_dec  = cmd_t'({rx_q[0], MOSI});
  assign abort    = SS_n && (state != ST_IDLE) && (state != ST_DONE);
  assign busy     = (state != ST_IDLE);
  assign tx_ready = (state == ST_WAIT_TX);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    miso_n   = MISO;
    err_n    = 1'b0;
    shift_rx = 1'b0;
    load_tx  = 1'b0;
    shift_tx = 1'b0;
    last_ok  = 1'b0;
    set_addr = 1'b0;
    clr_addr = 1'b0;
    if (abort) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      miso_n  = 1'b0;
      err_n   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          miso_n = 1'b0;
          if (!SS_n) begin
            state_n = ST_CMD;
            cnt_n   = CNT_W'(CW);
          end
        end
        ST_CMD: begin
          shift_rx = 1'b1;
          cnt_n    = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            cnt_n = CNT_W'(DW);
            case (cmd_dec)
              CMD_RD_ADDR: state_n = ST_READ_ADD;
              CMD_RD_DATA: begin
                if (CHECK_ADDR && !addr_seen) begin
                  state_n = ST_DONE;
                  cnt_n   = '0;
                  err_n   = 1'b1;
                end else begin
                  state_n = ST_READ_DATA;
                end
              end
              default: state_n = ST_WRITE;
            endcase
          end
        end
        ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
          shift_rx = 1'b1;
          cnt_n    = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            last_ok  = 1'b1;
            cnt_n    = '0;
            set_addr = (state == ST_READ_ADD);
            state_n  = (state == ST_READ_DATA) ? ST_WAIT_TX : ST_DONE;
          end
        end
        ST_WAIT_TX: begin
          if (tx_valid) begin
            load_tx = 1'b1;
            state_n = ST_TX_SHIFT;
            cnt_n   = CNT_W'(DW);
          end
        end
        ST_TX_SHIFT: begin
          miso_n   = tx_q[DW-1];
          shift_tx = 1'b1;
          cnt_n    = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_n  = ST_DONE;
            cnt_n    = '0;
            clr_addr = 1'b1;
          end
        end
        ST_DONE: begin
          if (SS_n) begin
            state_n = ST_IDLE;
            miso_n  = 1'b0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // rx_data is copied one cycle after the last bit and rx_valid follows a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      MISO      <= 1'b0;
      frame_err <= 1'b0;
      addr_seen <= 1'b0;
      cap_pend  <= 1'b0;
      val_pend  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      MISO      <= miso_n;
      frame_err <= err_n;
      if (set_addr) begin
        addr_seen <= 1'b1;
      end else if (clr_addr) begin
        addr_seen <= 1'b0;
      end
      cap_pend <= last_ok;
      val_pend <= cap_pend;
      if (cap_pend) begin
        rx_data <= rx_q;
      end
      rx_valid <= val_pend;
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench: frame vectors table plus hand-written read-data and reset sequences.
// dut1 checks the read address, dut0 has the check disabled and sees the same stimulus.
module tb_spi_slave_param;

  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, tx_valid;
  logic [7:0] tx_data;
  logic       miso1, rx_valid1, tx_ready1, frame_err1, busy1;
  logic [9:0] rx_data1;
  logic       miso0, rx_valid0, tx_ready0, frame_err0, busy0;
  logic [9:0] rx_data0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_slave_param #(.DW(8), .CW(2), .CHECK_ADDR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready1), .frame_err(frame_err1), .busy(busy1)
  );

  spi_slave_param #(.DW(8), .CW(2), .CHECK_ADDR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready0), .frame_err(frame_err0), .busy(busy0)
  );

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] pay;
    int         nb;       // bits sent before SS_n rises (cmd + payload)
    bit         hold;     // keep SS_n low after the frame
    bit         exp_v;
    int         exp_err;  // edge of frame_err pulse, -1 = none
    logic [9:0] exp_rx;
    bit         exp_rdy;
    bit         exp_v0;
    bit         exp_rdy0;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    logic [9:0] fr;
    int first_v = -1, nv = 0, first_e = -1, ne = 0, nv0 = 0;
    bit rdy = 1'b0, rdy0 = 1'b0;
    fr = {v.cmd, v.pay};
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      if (rx_valid1) begin
        if (first_v < 0) first_v = k;
        nv++;
      end
      if (frame_err1) begin
        if (first_e < 0) first_e = k;
        ne++;
      end
      if (tx_ready1) rdy = 1'b1;
      if (rx_valid0) nv0++;
      if (tx_ready0) rdy0 = 1'b1;
      MOSI = (k < v.nb) ? fr[9-k] : 1'b0;
      if (k == v.nb && !v.hold) SS_n = 1'b1;
    end
    if (v.exp_v) begin
      chk($sformatf("v%0d rx_valid edge", idx), first_v, 12);
      chk($sformatf("v%0d rx_valid width", idx), nv, 1);
    end else begin
      chk($sformatf("v%0d no rx_valid", idx), nv, 0);
    end
    if (v.exp_err < 0) begin
      chk($sformatf("v%0d no frame_err", idx), ne, 0);
    end else begin
      chk($sformatf("v%0d frame_err edge", idx), first_e, v.exp_err);
      chk($sformatf("v%0d frame_err width", idx), ne, 1);
    end
    chk($sformatf("v%0d rx_data", idx), rx_data1, v.exp_rx);
    chk($sformatf("v%0d tx_ready seen", idx), rdy, v.exp_rdy);
    chk($sformatf("v%0d nochk rx_valid", idx), (nv0 == 1), v.exp_v0);
    chk($sformatf("v%0d nochk tx_ready", idx), rdy0, v.exp_rdy0);
    if (!v.hold) chk($sformatf("v%0d idle busy", idx), busy1, 0);
  endtask

  initial begin
    logic [7:0] txp;
    vecs[0]  = '{2'b11, 8'h55, 10, 1'b0, 1'b0,  2, 10'h000, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{2'b00, 8'hA5, 10, 1'b0, 1'b1, -1, 10'h0A5, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{2'b01, 8'hFF,  6, 1'b0, 1'b0,  7, 10'h0A5, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 8'h5A, 10, 1'b0, 1'b1, -1, 10'h15A, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{2'b10, 8'h3C, 10, 1'b0, 1'b1, -1, 10'h23C, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{2'b00, 8'h81, 10, 1'b0, 1'b1, -1, 10'h081, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{2'b11, 8'h00, 10, 1'b1, 1'b1, -1, 10'h300, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{2'b11, 8'h77, 10, 1'b0, 1'b0,  2, 10'h300, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{2'b10, 8'h11, 10, 1'b0, 1'b1, -1, 10'h211, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2'b11, 8'h22, 10, 1'b1, 1'b1, -1, 10'h322, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{2'b00, 8'hC3, 10, 1'b0, 1'b1, -1, 10'h0C3, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{2'b11, 8'h99, 10, 1'b0, 1'b0,  2, 10'h0C3, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset MISO", miso1, 0);
    chk("reset rx_data", rx_data1, 0);
    chk("reset flags", {rx_valid1, tx_ready1, frame_err1, busy1}, 0);
    chk("reset nochk", {miso0, rx_data0, rx_valid0, tx_ready0, frame_err0, busy0}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_frame(i, vecs[i]);
      if (i == 6) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("wait tx_ready", tx_ready1, 1);
          chk("wait MISO", miso1, 0);
        end
        tx_data = 8'hD2; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("capture tx_ready", tx_ready1, 0);
        txp = 8'hD2;
        for (int b = 7; b >= 0; b--) begin
          @(negedge clk);
          chk($sformatf("MISO bit%0d", b), miso1, txp[b]);
          chk($sformatf("nochk MISO bit%0d", b), miso0, txp[b]);
        end
        @(negedge clk);
        chk("done hold busy", busy1, 1);
        chk("done hold MISO", miso1, txp[0]);
        SS_n = 1'b1;
        @(negedge clk);
        chk("done exit", {busy1, miso1}, 0);
      end
      if (i == 9) begin
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset MISO", miso1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async MISO", miso1, 0);
        chk("async busy", busy1, 0);
        chk("async tx_ready", tx_ready1, 0);
        chk("async rx_data", rx_data1, 0);
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parametrised successor to the fixed 10-bit SPI slave. It sits between the SPI pins and the RAM/register-file wrapper, and oversamples MOSI at the system clock (one bit per clk while SS_n is low). Frame format is CW command bits followed by DW payload bits, MSB first. Added over the previous generation: parametric widths, a ready/valid TX handshake, abort detection with an error pulse, and an optional address-before-read check.

Parameters:
DW, 8, payload bits per frame and bits shifted out on MISO.
CW, 2, command bits per frame; only the two LSBs of the command are decoded.
CHECK_ADDR, 1, 1 = a read-data command with no prior read-address is rejected with frame_err; 0 = it is accepted.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
SS_n  input  1  slave select, active low, synchronous to clk.
MOSI  input  1  serial data in, sampled on clk.
MISO  output  1  serial data out, registered.
rx_data  output  CW+DW  last completed frame as {cmd, payload}.
rx_valid  output  1  one-cycle pulse; rx_data is new.
tx_data  input  DW  read data from the memory side.
tx_valid  input  1  tx_data valid.
tx_ready  output  1  slave waiting for read data.
frame_err  output  1  one-cycle pulse on abort or rejected read.
busy  output  1  state != IDLE.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, MISO=0, rx_data=0, rx_valid=0, tx_ready=0, frame_err=0, addr_seen=0, counter=0.
- States: IDLE, CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, TX_SHIFT, DONE.
- Command decode (cmd[1:0]):
  - 00 or 01 -> WRITE.
  - 10 -> READ_ADD.
  - 11 -> READ_DATA.
- IDLE: SS_n low -> CMD with counter=CW. MISO held at 0.
- CMD: each cycle, shift MOSI into cmd and decrement counter. On the last command bit, go to the decoded state with counter=DW.
  - Rejected read: cmd=11, CHECK_ADDR=1 and addr_seen=0 -> DONE with frame_err pulse.
- WRITE / READ_ADD / READ_DATA: shift DW bits of MOSI into payload.
  - On the last bit: rx_data <= {cmd, payload}, and rx_valid pulses on the following cycle.
  - WRITE -> DONE. READ_ADD -> DONE and sets addr_seen. READ_DATA -> WAIT_TX.
- Latency: rx_valid rises on the (CW+DW+2)th clk edge after the edge on which IDLE first samples SS_n low (= 12 for defaults).
- WAIT_TX: tx_ready=1. When tx_valid && tx_ready: capture tx_data into the shift register, tx_ready=0, go to TX_SHIFT.
  - A tx_valid seen outside WAIT_TX is ignored.
- TX_SHIFT: MISO <= shift[MSB] each cycle for DW cycles; the first bit appears the cycle after capture. After the last bit: clear addr_seen, go to DONE.
- DONE: ignore MOSI and hold MISO at its last value. SS_n high -> IDLE, and MISO returns to 0.
- Abort: SS_n high in CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX or TX_SHIFT:
  - next state is IDLE, frame_err pulses 1 cycle, no rx_valid.
  - rx_data and addr_seen are unchanged; tx_ready drops.
- SS_n high in IDLE or DONE is not an error.
- Simultaneous events: SS_n high on the cycle of the last payload bit counts as an abort; abort takes priority over completion.
- Counter width: $clog2(max(CW,DW)+1). No wrap: the counter loads a new value at every state entry.
- Back-to-back frames: SS_n may go low the cycle after the IDLE return.
- Reset mid-frame: immediate return to reset values; no pulse is generated.

Decomposition:
- spi_slave_pkg:
  - state_t enum (8 states).
  - cmd_t enum: CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11.
  - function clog2-based counter width.
- One sub-module, spi_shift_reg: parametrised width, load/shift-in/shift-out enables. It is instantiated twice, once for the RX path and once for the TX path.
- FSM and counter live in the top-level module.

Test Plan:
- Write, DW=8: SS_n low, MOSI=00 then 0xA5 MSB first, SS_n high -> rx_data=0x0A5, rx_valid high exactly 1 cycle at edge 12, frame_err=0.
- Read address: cmd 10, payload 0x3C -> rx_data=0x23C, rx_valid pulse, addr_seen=1. A following WRITE frame leaves addr_seen=1.
- Read data: cmd 11, payload 0x00 -> rx_data=0x300 and rx_valid pulse; tx_ready=1. tx_valid is held low for 5 cycles, then tx_valid=1 with tx_data=0xD2 -> MISO sequence 1,1,0,1,0,0,1,0 on consecutive cycles; addr_seen=0 afterwards.
- Rejected read: CHECK_ADDR=1, cmd 11 with no prior 10 -> frame_err pulse after the 2nd command bit, no rx_valid, no tx_ready. With CHECK_ADDR=0 the same stimulus gives rx_valid and tx_ready.
- Abort: SS_n raised after 4 payload bits of a write -> IDLE next cycle, frame_err 1 cycle, rx_data keeps its previous value. A new full frame then completes normally.
- Async reset: rst_n pulsed low mid-TX_SHIFT, between clk edges -> MISO=0, busy=0, tx_ready=0 immediately; the next frame decodes correctly.
